cdc_clear_ctrl_half: RTL and testbench
======================================

Name: cdc_clear_ctrl_half

Overview:
- One half of the clear sequencer for the team's clearable 2-phase CDC channels.
- One instance sits in each clock domain; the two halves talk over a 2-phase handshake.
- Together they run a fixed sequence on both ends of a CDC link: isolate, clear, post-clear, release.
- The sequence is driven through the `isolate_*` and `clear_*` pins of the local CDC src/dst halves, so both ends are flushed coherently with no data loss or spurious valid.

Parameters:
- IS_MASTER, 0: 1 = this half sequences the phases; 0 = this half follows the partner's phase commands.
- SYNC_STAGES, 2: flip-flop depth of every incoming async synchroniser (min 2).
- CLEAR_CYCLES, 2: number of cycles `clear_o` is held high per half (1..255).
- CLEAR_ON_RESET, 1: master only; run one full sequence automatically after `rst_ni` deasserts.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  single-cycle request to start a clear sequence (either half)
- busy_o  out  1  sequence in progress
- isolate_o  out  1  to local CDC half: stop accepting and issuing handshakes
- isolate_ack_i  in  1  local CDC half confirms it is isolated
- clear_o  out  1  to the `clear_i` input of the local CDC half
- async_phase_req_o  out  1  master: toggles once per phase command
- async_phase_o  out  2  master: phase code; stable while the toggle is unacknowledged
- async_phase_ack_i  in  1  master: partner ack toggle
- async_phase_req_i  in  1  slave: phase toggle from master
- async_phase_i  in  2  slave: phase code from master
- async_phase_ack_o  out  1  slave: ack toggle to master
- async_clr_req_o  out  1  slave: toggles once per accepted `clear_i`
- async_clr_req_i  in  1  master: slave's clear-request toggle
- error_o  out  1  only with the optional feature

Behaviour:
- Reset values: all outputs 0; all toggle registers 0; FSM in IDLE.
- Unused ports are tied off per IS_MASTER: outputs drive 0, inputs are ignored.
- Phase codes: 0 RELEASE, 1 ISOLATE, 2 CLEAR, 3 POST.
- Master FSM states: IDLE, ISOLATE, CLEAR, POST, RELEASE, FINISH.
  - IDLE exits on any trigger: `clear_i`, a change in synced `async_clr_req_i`, or the first cycle after reset when CLEAR_ON_RESET=1.
  - Entering ISOLATE (cycle after trigger): `isolate_o`=1, `busy_o`=1; toggle `async_phase_req_o` with code 1.
  - ISOLATE -> CLEAR when `isolate_ack_i`=1 AND the partner ack toggle has matched. On entry: `clear_o`=1, toggle req with code 2.
  - CLEAR -> POST after `clear_o` has been high exactly CLEAR_CYCLES cycles AND the ack has matched. On entry: `clear_o`=0, `isolate_o` stays 1, toggle req with code 3.
  - POST -> RELEASE on ack match. On entry: `isolate_o`=0, toggle req with code 0.
  - RELEASE -> FINISH on ack match; FINISH drops `busy_o` and returns to IDLE next cycle.
- Slave side:
  - Detects a change in synced `async_phase_req_i` and samples `async_phase_i` in that same cycle.
  - Code 1: `isolate_o`=1; ack once `isolate_ack_i`=1.
  - Code 2: `clear_o`=1 for CLEAR_CYCLES cycles, then ack.
  - Code 3: `clear_o`=0; ack next cycle.
  - Code 0: `isolate_o`=0; ack next cycle.
  - Ack = toggle `async_phase_ack_o`.
  - `busy_o` rises on code 1 and falls with the code-0 ack.
- Both halves are isolated before either clears, and each clears before release.
- Triggers arriving while `busy_o`=1 are merged into the running sequence; they never queue a second one. Slave `clear_i` while busy does not toggle `async_clr_req_o`.
- Simultaneous local `clear_i` and remote clr-request toggle: exactly one sequence runs.
- `async_phase_o` changes only together with its req toggle.
- Reset mid-sequence: both halves must reset together; each returns to IDLE with outputs at 0. No recovery from a single-sided reset without the optional feature.

Optional Feature:
- Macro: CDC_CLEAR_CTRL_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES, default 1024.
  - A 16-bit counter runs in every wait state and restarts on each state change.
  - On expiry: `error_o` pulses for 1 cycle, `clear_o`=0, `isolate_o`=0, `busy_o`=0, FSM goes to IDLE.
  - The master also realigns its req toggle to the synced ack value.
- When undefined: no counter, `error_o` is tied to 0, and the FSM waits indefinitely.

Decomposition:
- Shared package `cdc_clear_pkg`:
  - phase enum type `cdc_clear_phase_e` (2-bit, codes above)
  - master state enum
  - constant defaults for SYNC_STAGES and CLEAR_CYCLES
- Existing `sync` cell for every incoming async bit except `async_phase_i`, which is sampled only on a toggle.
- One natural sub-module, `cdc_clear_toggle_rx`: sync plus edge detect on a toggle, outputting a 1-cycle `event_o`. It is instantiated for phase req, phase ack and clr req.

Test Plan:
- Master+slave, SYNC_STAGES=2, CLEAR_CYCLES=3, CLEAR_ON_RESET=0, `isolate_ack_i` tied high; master `clear_i` pulse -> both `isolate_o` rise; each `clear_o` high exactly 3 cycles; master `clear_o` rises only after slave `isolate_o`=1; both `busy_o` low at end; codes 1,2,3,0 seen in order.
- Slave `clear_i` pulse -> `async_clr_req_o` toggles once; master starts ISOLATE within SYNC_STAGES+2 master cycles; one full sequence.
- Slave `isolate_ack_i` held low 50 cycles -> master stays in ISOLATE; no `clear_o` on either side until 50 cycles pass; then sequence completes.
- Master `clear_i` and slave clr-request in same cycle, plus a second `clear_i` during CLEAR -> exactly four phase toggles total.
- CLEAR_ON_RESET=1, deassert reset -> one sequence runs with no `clear_i`. Clocks 100 MHz/37 MHz, both fast/slow orderings.
- With CDC_CLEAR_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=64, slave ack never returns -> `error_o` 1-cycle pulse at wait cycle 64; master outputs 0, IDLE.

Source files
------------

// File: rtl/cdc_clear_pkg.sv
// Shared types and defaults for the two halves of the CDC clear sequencer.
package cdc_clear_pkg;

    // Phase command carried from master to slave alongside each request toggle.
    typedef enum logic [1:0] {
        PhRelease = 2'd0,
        PhIsolate = 2'd1,
        PhClear   = 2'd2,
        PhPost    = 2'd3
    } cdc_clear_phase_e;

    // Master sequencing states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIsolate = 3'd1,
        StClear   = 3'd2,
        StPost    = 3'd3,
        StRelease = 3'd4,
        StFinish  = 3'd5
    } cdc_clear_mst_state_e;

    localparam int unsigned SyncStagesDefault  = 2;
    localparam int unsigned ClearCyclesDefault = 2;

endpackage

// File: rtl/cdc_clear_toggle_rx.sv
// Receives a 2-phase toggle: synchronises it and flags each change for one cycle.
module cdc_clear_toggle_rx
    import cdc_clear_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic toggle_i,
    output logic level_o,
    output logic event_o
);

    logic level_sync;
    logic level_q, level_d;

    sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (toggle_i),
        .q_o   (level_sync)
    );

    // Remember the last synced level for edge detection.
    always_comb begin
        level_d = level_sync;
    end

    // Edge-detect register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_sync;
    assign event_o = level_sync ^ level_q;

endmodule

// File: rtl/sync.sv
// Plain multi-flop synchroniser for a single asynchronous bit.
module sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q, sync_d;

    // Shift the incoming bit through the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Synchroniser flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_clear_ctrl_half.sv
// One half of the clear sequencer for clearable 2-phase CDC channels.
// IS_MASTER selects sequencing (master) or following (slave) behaviour.
// Optional watchdog: define CDC_CLEAR_CTRL_TIMEOUT_EN.
module cdc_clear_ctrl_half
    import cdc_clear_pkg::*;
#(
    parameter int unsigned IS_MASTER      = 0,
    parameter int unsigned SYNC_STAGES    = SyncStagesDefault,
    parameter int unsigned CLEAR_CYCLES   = ClearCyclesDefault,
    parameter int unsigned CLEAR_ON_RESET = 1
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    output logic       busy_o,
    output logic       isolate_o,
    input  logic       isolate_ack_i,
    output logic       clear_o,
    output logic       async_phase_req_o,
    output logic [1:0] async_phase_o,
    input  logic       async_phase_ack_i,
    input  logic       async_phase_req_i,
    input  logic [1:0] async_phase_i,
    output logic       async_phase_ack_o,
    output logic       async_clr_req_o,
    input  logic       async_clr_req_i,
    output logic       error_o
);

    localparam logic [7:0] ClrCyc = 8'(CLEAR_CYCLES);
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
`else
    assign error_o = 1'b0;
`endif

    if (IS_MASTER != 0) begin : g_master
        cdc_clear_mst_state_e state_q, state_d;
        cdc_clear_phase_e     phase_q, phase_d;
        logic       req_q, req_d, iso_q, iso_d, clr_q, clr_d, busy_q, busy_d, init_q, init_d;
        logic [7:0] cnt_q, cnt_d;
        logic       ack_level, ack_evt_unused, clr_evt, clr_level_unused;
        logic       ack_match, clr_done, trigger, unused_slave_in;
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
        logic [15:0] tmo_q, tmo_d;
        logic        err_q, err_d;
`endif

        cdc_clear_toggle_rx #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ack_rx (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .toggle_i(async_phase_ack_i),
            .level_o (ack_level),
            .event_o (ack_evt_unused)
        );

        cdc_clear_toggle_rx #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_clr_rx (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .toggle_i(async_clr_req_i),
            .level_o (clr_level_unused),
            .event_o (clr_evt)
        );

        assign unused_slave_in = ^{async_phase_req_i, async_phase_i};
        // Partner has acknowledged the most recent command once its toggle matches ours.
        assign ack_match = (ack_level == req_q);
        assign clr_done  = !clr_q || (cnt_q == ClrCyc);
        assign trigger   = clear_i || clr_evt || ((CLEAR_ON_RESET != 0) && init_q);

        // Next-state and phase command sequencing.
        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            req_d   = req_q;
            iso_d   = iso_q;
            clr_d   = clr_q;
            busy_d  = busy_q;
            cnt_d   = cnt_q;
            init_d  = 1'b0;
            // Local clear pulse width is independent of when the partner acks.
            if (clr_q) begin
                if (cnt_q == ClrCyc) begin
                    clr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            unique case (state_q)
                StIdle, StFinish: begin
                    if (state_q == StFinish) state_d = StIdle;
                    if (trigger) begin
                        state_d = StIsolate;
                        iso_d   = 1'b1;
                        busy_d  = 1'b1;
                        req_d   = ~req_q;
                        phase_d = PhIsolate;
                    end
                end
                StIsolate: begin
                    if (isolate_ack_i && ack_match) begin
                        state_d = StClear;
                        clr_d   = 1'b1;
                        cnt_d   = 8'd1;
                        req_d   = ~req_q;
                        phase_d = PhClear;
                    end
                end
                StClear: begin
                    if (clr_done && ack_match) begin
                        state_d = StPost;
                        clr_d   = 1'b0;
                        req_d   = ~req_q;
                        phase_d = PhPost;
                    end
                end
                StPost: begin
                    if (ack_match) begin
                        state_d = StRelease;
                        iso_d   = 1'b0;
                        req_d   = ~req_q;
                        phase_d = PhRelease;
                    end
                end
                StRelease: begin
                    if (ack_match) begin
                        state_d = StFinish;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
            err_d = 1'b0;
            tmo_d = 16'd0;
            if ((state_q inside {StIsolate, StClear, StPost, StRelease}) && (state_d == state_q)) begin
                if (tmo_q == TmoLast) begin
                    state_d = StIdle;
                    iso_d   = 1'b0;
                    clr_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    // Realign so the next command is seen as unacknowledged.
                    req_d   = ack_level;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
`endif
        end

        // Master state registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= StIdle;
                phase_q <= PhRelease;
                req_q   <= 1'b0;
                iso_q   <= 1'b0;
                clr_q   <= 1'b0;
                busy_q  <= 1'b0;
                cnt_q   <= 8'd0;
                init_q  <= 1'b1;
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
                tmo_q   <= 16'd0;
                err_q   <= 1'b0;
`endif
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                req_q   <= req_d;
                iso_q   <= iso_d;
                clr_q   <= clr_d;
                busy_q  <= busy_d;
                cnt_q   <= cnt_d;
                init_q  <= init_d;
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
                tmo_q   <= tmo_d;
                err_q   <= err_d;
`endif
            end
        end

`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
        assign error_o = err_q;
`endif
        assign busy_o            = busy_q;
        assign isolate_o         = iso_q;
        assign clear_o           = clr_q;
        assign async_phase_req_o = req_q;
        assign async_phase_o     = phase_q;
        assign async_phase_ack_o = 1'b0;
        assign async_clr_req_o   = 1'b0;
    end else begin : g_slave
        cdc_clear_phase_e code_q, code_d, phase_in;
        logic       pend_q, pend_d, ack_q, ack_d, creq_q, creq_d, cpend_q, cpend_d;
        logic       iso_q, iso_d, clr_q, clr_d, busy_q, busy_d;
        logic [7:0] cnt_q, cnt_d;
        logic       req_evt, req_level_unused, unused_master_in;
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
        logic [15:0] tmo_q, tmo_d;
        logic        err_q, err_d;
`endif

        cdc_clear_toggle_rx #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_req_rx (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .toggle_i(async_phase_req_i),
            .level_o (req_level_unused),
            .event_o (req_evt)
        );

        assign unused_master_in = ^{async_phase_ack_i, async_clr_req_i};
        // The code is stable while its toggle is in flight, so sampling on the event is safe.
        assign phase_in = cdc_clear_phase_e'(async_phase_i);

        // Follow phase commands and acknowledge each once its local effect is done.
        always_comb begin
            code_d  = code_q;
            pend_d  = pend_q;
            ack_d   = ack_q;
            creq_d  = creq_q;
            cpend_d = cpend_q;
            iso_d   = iso_q;
            clr_d   = clr_q;
            busy_d  = busy_q;
            cnt_d   = cnt_q;
            if (clr_q) begin
                if (cnt_q == ClrCyc) begin
                    clr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // Forward a local request only if none is running or already in flight.
            if (clear_i && !busy_q && !cpend_q && !req_evt) begin
                creq_d  = ~creq_q;
                cpend_d = 1'b1;
            end
            if (pend_q) begin
                unique case (code_q)
                    PhIsolate: begin
                        if (isolate_ack_i) begin
                            ack_d  = ~ack_q;
                            pend_d = 1'b0;
                        end
                    end
                    PhClear: begin
                        if (!clr_q || (cnt_q == ClrCyc)) begin
                            ack_d  = ~ack_q;
                            pend_d = 1'b0;
                        end
                    end
                    PhPost: begin
                        ack_d  = ~ack_q;
                        pend_d = 1'b0;
                    end
                    PhRelease: begin
                        ack_d  = ~ack_q;
                        pend_d = 1'b0;
                        busy_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            if (req_evt) begin
                code_d = phase_in;
                pend_d = 1'b1;
                unique case (phase_in)
                    PhIsolate: begin
                        iso_d   = 1'b1;
                        busy_d  = 1'b1;
                        cpend_d = 1'b0;
                    end
                    PhClear: begin
                        clr_d = 1'b1;
                        cnt_d = 8'd1;
                    end
                    PhPost:    clr_d = 1'b0;
                    PhRelease: iso_d = 1'b0;
                    default: ;
                endcase
            end
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
            err_d = 1'b0;
            tmo_d = 16'd0;
            if ((busy_q || cpend_q) && !req_evt && (ack_d == ack_q)) begin
                if (tmo_q == TmoLast) begin
                    iso_d   = 1'b0;
                    clr_d   = 1'b0;
                    busy_d  = 1'b0;
                    pend_d  = 1'b0;
                    cpend_d = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
`endif
        end

        // Slave state registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                code_q  <= PhRelease;
                pend_q  <= 1'b0;
                ack_q   <= 1'b0;
                creq_q  <= 1'b0;
                cpend_q <= 1'b0;
                iso_q   <= 1'b0;
                clr_q   <= 1'b0;
                busy_q  <= 1'b0;
                cnt_q   <= 8'd0;
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
                tmo_q   <= 16'd0;
                err_q   <= 1'b0;
`endif
            end else begin
                code_q  <= code_d;
                pend_q  <= pend_d;
                ack_q   <= ack_d;
                creq_q  <= creq_d;
                cpend_q <= cpend_d;
                iso_q   <= iso_d;
                clr_q   <= clr_d;
                busy_q  <= busy_d;
                cnt_q   <= cnt_d;
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
                tmo_q   <= tmo_d;
                err_q   <= err_d;
`endif
            end
        end

`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
        assign error_o = err_q;
`endif
        assign busy_o            = busy_q;
        assign isolate_o         = iso_q;
        assign clear_o           = clr_q;
        assign async_phase_req_o = 1'b0;
        assign async_phase_o     = 2'b00;
        assign async_phase_ack_o = ack_q;
        assign async_clr_req_o   = creq_q;
    end

endmodule

// File: tb/tb_cdc_clear_ctrl_half.sv
// Bench: pair A (master fast, slave slow, no clear on reset) runs random and directed
// sequences; pair B (master slow, slave fast, clear on reset) runs its automatic sequence.
module tb_cdc_clear_ctrl_half;

    localparam int unsigned CC = 3;

    logic m_clk = 1'b0;
    logic s_clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 m_clk = ~m_clk;
    always begin
        #13 s_clk = 1'b1;
        #14 s_clk = 1'b0;
    end

    // Pair A
    logic       m_clear = 1'b0, s_clear = 1'b0;
    logic       m_busy, m_iso, m_clr, m_preq, m_pack_nc, m_creq_nc, m_err;
    logic [1:0] m_phase;
    logic       s_busy, s_iso, s_clr, s_preq_nc, s_pack, s_creq, s_err, s_iso_ack;
    logic [1:0] s_phase_nc;
    int         s_iso_delay = 0;
    int         s_iso_cnt = 0;

    // Pair B
    logic       bm_busy, bm_iso, bm_clr, bm_preq, bm_pack_nc, bm_creq_nc, bm_err;
    logic [1:0] bm_phase;
    logic       bs_busy, bs_iso, bs_clr, bs_preq_nc, bs_pack, bs_creq, bs_err;
    logic [1:0] bs_phase_nc;

    cdc_clear_ctrl_half #(.IS_MASTER(1), .SYNC_STAGES(2), .CLEAR_CYCLES(CC), .CLEAR_ON_RESET(0))
    u_mst (
        .clk_i(m_clk), .rst_ni(rst_n), .clear_i(m_clear), .busy_o(m_busy), .isolate_o(m_iso),
        .isolate_ack_i(1'b1), .clear_o(m_clr), .async_phase_req_o(m_preq),
        .async_phase_o(m_phase), .async_phase_ack_i(s_pack), .async_phase_req_i(1'b0),
        .async_phase_i(2'b00), .async_phase_ack_o(m_pack_nc), .async_clr_req_o(m_creq_nc),
        .async_clr_req_i(s_creq), .error_o(m_err)
    );

    cdc_clear_ctrl_half #(.IS_MASTER(0), .SYNC_STAGES(2), .CLEAR_CYCLES(CC), .CLEAR_ON_RESET(0))
    u_slv (
        .clk_i(s_clk), .rst_ni(rst_n), .clear_i(s_clear), .busy_o(s_busy), .isolate_o(s_iso),
        .isolate_ack_i(s_iso_ack), .clear_o(s_clr), .async_phase_req_o(s_preq_nc),
        .async_phase_o(s_phase_nc), .async_phase_ack_i(1'b0), .async_phase_req_i(m_preq),
        .async_phase_i(m_phase), .async_phase_ack_o(s_pack), .async_clr_req_o(s_creq),
        .async_clr_req_i(1'b0), .error_o(s_err)
    );

    cdc_clear_ctrl_half #(.IS_MASTER(1), .SYNC_STAGES(2), .CLEAR_CYCLES(CC), .CLEAR_ON_RESET(1))
    u_bmst (
        .clk_i(s_clk), .rst_ni(rst_n), .clear_i(1'b0), .busy_o(bm_busy), .isolate_o(bm_iso),
        .isolate_ack_i(1'b1), .clear_o(bm_clr), .async_phase_req_o(bm_preq),
        .async_phase_o(bm_phase), .async_phase_ack_i(bs_pack), .async_phase_req_i(1'b0),
        .async_phase_i(2'b00), .async_phase_ack_o(bm_pack_nc), .async_clr_req_o(bm_creq_nc),
        .async_clr_req_i(bs_creq), .error_o(bm_err)
    );

    cdc_clear_ctrl_half #(.IS_MASTER(0), .SYNC_STAGES(2), .CLEAR_CYCLES(CC), .CLEAR_ON_RESET(1))
    u_bslv (
        .clk_i(m_clk), .rst_ni(rst_n), .clear_i(1'b0), .busy_o(bs_busy), .isolate_o(bs_iso),
        .isolate_ack_i(1'b1), .clear_o(bs_clr), .async_phase_req_o(bs_preq_nc),
        .async_phase_o(bs_phase_nc), .async_phase_ack_i(1'b0), .async_phase_req_i(bm_preq),
        .async_phase_i(bm_phase), .async_phase_ack_o(bs_pack), .async_clr_req_o(bs_creq),
        .async_clr_req_i(1'b0), .error_o(bs_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Local CDC half model for the slave: acks isolation after s_iso_delay cycles.
    always @(posedge s_clk) s_iso_cnt <= s_iso ? s_iso_cnt + 1 : 0;
    assign s_iso_ack = s_iso && (s_iso_cnt >= s_iso_delay);

    // Observation logs
    logic [1:0] phase_log[$];
    logic [1:0] b_log[$];
    int         m_lens[$];
    int         s_lens[$];
    int         m_len = 0, s_len = 0, creq_toggles = 0, bm_clr_n = 0, bs_clr_n = 0;
    logic       m_preq_p = 1'b0, m_clr_p = 1'b0, s_clr_p = 1'b0, s_creq_p = 1'b0, bm_preq_p = 1'b0;
    logic [1:0] m_phase_p = 2'b00;

    // Master-domain monitor of pair A.
    always @(negedge m_clk) begin
        if (rst_n) begin
            if (m_preq != m_preq_p) phase_log.push_back(m_phase);
            if (m_phase != m_phase_p) check_eq("phase_with_req", 32'(m_preq ^ m_preq_p), 32'd1);
            if (m_clr && !m_clr_p) check_eq("m_clr_after_s_iso_ack", 32'(s_iso_ack), 32'd1);
            if (m_clr) m_len <= m_len + 1;
            else if (m_clr_p) begin
                m_lens.push_back(m_len);
                m_len <= 0;
            end
            if (bs_clr) bs_clr_n <= bs_clr_n + 1;
        end
        m_preq_p  <= m_preq;
        m_phase_p <= m_phase;
        m_clr_p   <= m_clr;
    end

    // Slave-domain monitor of pair A, plus pair B master domain.
    always @(negedge s_clk) begin
        if (rst_n) begin
            if (s_clr && !s_clr_p) begin
                check_eq("s_clr_after_iso_ack", 32'(s_iso_cnt >= s_iso_delay), 32'd1);
                check_eq("s_clr_after_m_iso", 32'(m_iso), 32'd1);
            end
            if (s_clr) s_len <= s_len + 1;
            else if (s_clr_p) begin
                s_lens.push_back(s_len);
                s_len <= 0;
            end
            if (s_creq != s_creq_p) creq_toggles <= creq_toggles + 1;
            if (bm_preq != bm_preq_p) b_log.push_back(bm_phase);
            if (bm_clr) bm_clr_n <= bm_clr_n + 1;
        end
        s_clr_p   <= s_clr;
        s_creq_p  <= s_creq;
        bm_preq_p <= bm_preq;
    end

    // Reference: every sequence issues these codes in order.
    logic [1:0] exp_codes[4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    // kind 0: master clear_i; 1: slave clear_i; 2: both at once plus a merged extra clear_i.
    task automatic run_seq(input int kind, input int dly);
        int n, p0, ml0, sl0, c0, exp_creq;
        s_iso_delay = dly;
        p0  = phase_log.size();
        ml0 = m_lens.size();
        sl0 = s_lens.size();
        c0  = creq_toggles;
        exp_creq = (kind == 0) ? 0 : 1;
        if (kind == 0) begin
            @(negedge m_clk) m_clear = 1'b1;
            @(negedge m_clk) m_clear = 1'b0;
        end else if (kind == 1) begin
            @(negedge s_clk) s_clear = 1'b1;
            @(posedge s_clk);
            #1 s_clear = 1'b0;
            n = 0;
            while (!m_iso && n < 20) begin
                @(posedge m_clk);
                #1 n++;
            end
            check_eq("clr_req_latency", 32'(n <= 4), 32'd1);
        end else begin
            @(negedge m_clk);
            m_clear = 1'b1;
            s_clear = 1'b1;
            @(posedge m_clk);
            #1 m_clear = 1'b0;
            @(posedge s_clk);
            #1 s_clear = 1'b0;
            n = 0;
            while (!m_clr && n < 2000) begin
                @(posedge m_clk);
                #1 n++;
            end
            check_eq("reach_clear", 32'(m_clr), 32'd1);
            @(negedge m_clk) m_clear = 1'b1;
            @(negedge m_clk) m_clear = 1'b0;
        end
        n = 0;
        while (!m_busy && !m_iso && n < 30) begin
            @(posedge m_clk);
            #1 n++;
        end
        n = 0;
        while ((m_busy || s_busy) && n < 4000) begin
            @(posedge m_clk);
            #1 n++;
        end
        check_eq("seq_done", 32'(n < 4000), 32'd1);
        repeat (10) @(posedge m_clk);
        #1;
        check_eq("phase_toggles", 32'(phase_log.size() - p0), 32'd4);
        if (phase_log.size() >= p0 + 4)
            for (int i = 0; i < 4; i++) check_eq("phase_code", 32'(phase_log[p0+i]), 32'(exp_codes[i]));
        check_eq("m_clr_pulses", 32'(m_lens.size() - ml0), 32'd1);
        if (m_lens.size() > ml0) check_eq("m_clr_len", 32'(m_lens[ml0]), CC);
        check_eq("s_clr_pulses", 32'(s_lens.size() - sl0), 32'd1);
        if (s_lens.size() > sl0) check_eq("s_clr_len", 32'(s_lens[sl0]), CC);
        check_eq("clr_req_toggles", 32'(creq_toggles - c0), 32'(exp_creq));
        check_eq("end_outputs", 32'({m_busy, s_busy, m_iso, s_iso, m_clr, s_clr, m_err}), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge s_clk);
        #1;
        check_eq("reset_a", 32'({m_busy, m_iso, m_clr, m_preq, m_phase, m_pack_nc, m_creq_nc,
                                  s_busy, s_iso, s_clr, s_preq_nc, s_phase_nc, s_pack, s_creq}),
                 32'd0);
        check_eq("reset_b", 32'({bm_busy, bm_iso, bm_clr, bm_preq, bm_phase, bs_busy, bs_iso,
                                  bs_clr, bs_pack, bs_creq, bm_err, bs_err, m_err, s_err}), 32'd0);
        @(negedge s_clk) rst_n = 1'b1;

        // Pair B sequences itself after reset.
        n = 0;
        while (!bm_busy && n < 20) begin
            @(posedge s_clk);
            #1 n++;
        end
        check_eq("b_auto_start", 32'(bm_busy), 32'd1);
        n = 0;
        while ((bm_busy || bs_busy) && n < 2000) begin
            @(posedge s_clk);
            #1 n++;
        end
        repeat (5) @(posedge s_clk);
        #1;
        check_eq("b_toggles", 32'(b_log.size()), 32'd4);
        if (b_log.size() >= 4)
            for (int i = 0; i < 4; i++) check_eq("b_code", 32'(b_log[i]), 32'(exp_codes[i]));
        check_eq("b_m_clr_cycles", 32'(bm_clr_n), CC);
        check_eq("b_s_clr_cycles", 32'(bs_clr_n), CC);
        check_eq("b_end", 32'({bm_busy, bs_busy, bm_iso, bs_iso}), 32'd0);

        // Pair A: directed then random.
        run_seq(0, 0);
        run_seq(1, 0);
        run_seq(0, 50);
        run_seq(2, 3);
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(1, 10)) @(posedge m_clk);
            run_seq(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)));
        end
        check_eq("b_no_rerun", 32'(b_log.size()), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
